// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo puncture serializer: FSM states and the
// layout of one buffered coded pair.
package turbo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND0 = 2'd1,
        ST_SEND1 = 2'd2
    } state_t;

    localparam int B0      = 0;
    localparam int B1      = 1;
    localparam int KEEP1   = 2;
    localparam int LAST    = 3;
    localparam int ENTRY_W = 4;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic last,
        input logic keep1,
        input logic b1,
        input logic b0
    );
        logic [ENTRY_W-1:0] e;
        e        = '0;
        e[B0]    = b0;
        e[B1]    = b1;
        e[KEEP1] = keep1;
        e[LAST]  = last;
        return e;
    endfunction

endpackage

// File: rtl/turbo_puncture_serializer_if.sv
// Coded-pair input stream and serial output stream of the serializer.
// The design uses the slave view; the producer/consumer side uses master.
interface turbo_puncture_serializer_if;

    logic in_valid;
    logic in_bit0;
    logic in_bit1;
    logic in_last;
    logic in_ready;
    logic out_ready;
    logic out_valid;
    logic out_bit;
    logic out_last;

    modport slave (
        input  in_valid, in_bit0, in_bit1, in_last, out_ready,
        output in_ready, out_valid, out_bit, out_last
    );

    modport master (
        output in_valid, in_bit0, in_bit1, in_last, out_ready,
        input  in_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/turbo_pair_fifo.sv
// Synchronous FIFO of coded-pair entries; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module turbo_pair_fifo
    import turbo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_data    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is not reset; the pointers alone decide which words are meaningful.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/turbo_puncture_serializer.sv
// Punctures the parity bit of each coded pair by a periodic keep mask and
// serializes the surviving bits through a FIFO with valid/ready flow control.
module turbo_puncture_serializer
    import turbo_pkg::*;
#(
    parameter int              DEPTH   = 8,
    parameter int              PERIOD  = 2,
    parameter logic [PERIOD-1:0] PATTERN = 2'b01,
    parameter int              CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    turbo_puncture_serializer_if.slave   bus,
    output logic                         overflow,
    output logic [CNT_W-1:0]             bits_sent
);

    localparam int          PH_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [15:0] PAT_EXT = 16'(PATTERN);

    state_t             r_state;
    state_t             w_next_state;
    logic [ENTRY_W-1:0] r_hold;
    logic [PH_W-1:0]    r_phase;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_bits_sent;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_keep1;
    logic [ENTRY_W-1:0] w_head;
    logic               w_out_valid;
    logic               w_out_bit;
    logic               w_out_last;
    logic               w_out_hs;

    assign bus.in_ready  = !w_full;
    assign w_push        = bus.in_valid && !w_full;
    assign w_keep1       = PAT_EXT[r_phase];
    assign w_out_hs      = w_out_valid && bus.out_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_bit   = w_out_bit;
    assign bus.out_last  = w_out_last;
    assign overflow      = r_overflow;
    assign bits_sent     = r_bits_sent;

    turbo_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (pack_entry(bus.in_last, w_keep1, bus.in_bit1, bus.in_bit0)),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Phase restarts at every block boundary so each block sees the same mask alignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (w_push) begin
            if (bus.in_last || (r_phase == PH_W'(PERIOD - 1))) r_phase <= '0;
            else                                                r_phase <= r_phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (bus.in_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) r_hold <= w_head;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_out_valid  = 1'b0;
        w_out_bit    = 1'b0;
        w_out_last   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SEND0;
                end
            end
            ST_SEND0: begin
                w_out_valid = 1'b1;
                w_out_bit   = r_hold[B0];
                w_out_last  = r_hold[LAST] && !r_hold[KEEP1];
                if (w_out_hs) begin
                    if (r_hold[KEEP1]) begin
                        w_next_state = ST_SEND1;
                    end else begin
                        w_pop        = !w_empty;
                        w_next_state = w_empty ? ST_IDLE : ST_SEND0;
                    end
                end
            end
            ST_SEND1: begin
                w_out_valid = 1'b1;
                w_out_bit   = r_hold[B1];
                w_out_last  = r_hold[LAST];
                // Reload on the finishing handshake keeps the stream free of bubbles.
                if (w_out_hs) begin
                    w_pop        = !w_empty;
                    w_next_state = w_empty ? ST_IDLE : ST_SEND0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bits_sent <= '0;
        end else if (w_out_hs) begin
            if (w_out_last) r_bits_sent <= '0;
            else            r_bits_sent <= r_bits_sent + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_turbo_puncture_serializer.sv
// Bench for the puncture serializer: two differently parameterised instances
// share one stimulus and are checked every cycle against a queue-level model.
module tb_turbo_puncture_serializer;

    localparam int         DEPTH0  = 8;
    localparam int         PERIOD0 = 2;
    localparam logic [1:0] PAT0    = 2'b01;
    localparam int         DEPTH1  = 4;
    localparam int         PERIOD1 = 3;
    localparam logic [2:0] PAT1    = 3'b110;

    logic        clk = 1'b0;
    logic        reset;
    logic        ovf0, ovf1;
    logic [15:0] sent0, sent1;

    always #5 clk = ~clk;

    turbo_puncture_serializer_if bus0 ();
    turbo_puncture_serializer_if bus1 ();

    turbo_puncture_serializer #(
        .DEPTH(DEPTH0), .PERIOD(PERIOD0), .PATTERN(PAT0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .overflow(ovf0), .bits_sent(sent0)
    );

    turbo_puncture_serializer #(
        .DEPTH(DEPTH1), .PERIOD(PERIOD1), .PATTERN(PAT1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .overflow(ovf1), .bits_sent(sent1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Driven inputs, shared by both instances.
    logic s_valid, s_b0, s_b1, s_last, s_ready;

    // Model: pending pairs {last,keep,b1,b0}; bits of the pair being sent {bit,last}.
    logic [3:0] m_q   [2][$];
    logic [1:0] m_cur [2][$];
    int         m_phase [2];
    int         m_cnt   [2];
    bit         m_ovf   [2];

    // Bits handshaked by each instance, {bit,last}.
    logic [1:0] cap0 [$];
    logic [1:0] cap1 [$];

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? DEPTH0 : DEPTH1;
    endfunction

    function automatic int period_of(input int d);
        return (d == 0) ? PERIOD0 : PERIOD1;
    endfunction

    function automatic logic keep_of(input int d, input int ph);
        return (d == 0) ? PAT0[ph] : PAT1[ph];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_q[d].delete();
            m_cur[d].delete();
            m_phase[d] = 0;
            m_cnt[d]   = 0;
            m_ovf[d]   = 0;
        end
    endtask

    // Effect of one rising edge, given the inputs currently driven.
    task automatic model_step(input int d);
        bit         hs, acc;
        logic [3:0] p;
        logic [1:0] b;
        hs  = (m_cur[d].size() > 0) && s_ready;
        acc = s_valid && (m_q[d].size() < depth_of(d));
        if (s_valid && !acc) m_ovf[d] = 1;
        if (hs) begin
            b = m_cur[d].pop_front();
            m_cnt[d] = b[0] ? 0 : (m_cnt[d] + 1) % 65536;
        end
        if (m_cur[d].size() == 0 && m_q[d].size() > 0) begin
            p = m_q[d].pop_front();
            m_cur[d].push_back({p[0], p[3] & ~p[2]});
            if (p[2]) m_cur[d].push_back({p[1], p[3]});
        end
        if (acc) begin
            m_q[d].push_back({s_last, keep_of(d, m_phase[d]), s_b1, s_b0});
            m_phase[d] = s_last ? 0 : (m_phase[d] + 1) % period_of(d);
        end
    endtask

    task automatic compare(input int d);
        logic        ir, ov, ob, ol, of;
        logic [15:0] bs;
        if (d == 0) begin
            ir = bus0.in_ready; ov = bus0.out_valid; ob = bus0.out_bit;
            ol = bus0.out_last; of = ovf0; bs = sent0;
        end else begin
            ir = bus1.in_ready; ov = bus1.out_valid; ob = bus1.out_bit;
            ol = bus1.out_last; of = ovf1; bs = sent1;
        end
        check("in_ready", d, 32'(ir), 32'(m_q[d].size() < depth_of(d)));
        check("out_valid", d, 32'(ov), 32'(m_cur[d].size() > 0));
        if (m_cur[d].size() > 0) begin
            check("out_bit", d, 32'(ob), 32'(m_cur[d][0][1]));
            check("out_last", d, 32'(ol), 32'(m_cur[d][0][0]));
        end
        check("overflow", d, 32'(of), 32'(m_ovf[d]));
        check("bits_sent", d, 32'(bs), 32'(m_cnt[d]));
    endtask

    task automatic drive(input logic v, input logic b0, input logic b1, input logic l, input logic rdy);
        s_valid = v; s_b0 = b0; s_b1 = b1; s_last = l; s_ready = rdy;
        bus0.in_valid = v; bus0.in_bit0 = b0; bus0.in_bit1 = b1; bus0.in_last = l; bus0.out_ready = rdy;
        bus1.in_valid = v; bus1.in_bit0 = b0; bus1.in_bit1 = b1; bus1.in_last = l; bus1.out_ready = rdy;
    endtask

    task automatic cycle(input logic v, input logic b0, input logic b1, input logic l, input logic rdy);
        @(negedge clk);
        compare(0);
        compare(1);
        drive(v, b0, b1, l, rdy);
        if (bus0.out_valid && rdy) cap0.push_back({bus0.out_bit, bus0.out_last});
        if (bus1.out_valid && rdy) cap1.push_back({bus1.out_bit, bus1.out_last});
        model_step(0);
        model_step(1);
    endtask

    task automatic reset_checks();
        check("rst_in_ready", 0, 32'(bus0.in_ready), 32'd1);
        check("rst_out_valid", 0, 32'(bus0.out_valid), 32'd0);
        check("rst_out_bit", 0, 32'(bus0.out_bit), 32'd0);
        check("rst_out_last", 0, 32'(bus0.out_last), 32'd0);
        check("rst_overflow", 0, 32'(ovf0), 32'd0);
        check("rst_bits_sent", 0, 32'(sent0), 32'd0);
        check("rst_in_ready", 1, 32'(bus1.in_ready), 32'd1);
        check("rst_out_valid", 1, 32'(bus1.out_valid), 32'd0);
        check("rst_overflow", 1, 32'(ovf1), 32'd0);
        check("rst_bits_sent", 1, 32'(sent1), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_clear();
        #1;
        reset_checks();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] e0 [6];
        logic [1:0] e1 [6];
        int         vp, rp;

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(negedge clk);
        reset_checks();
        reset = 1'b0;

        // Single four-pair block, consumer always ready.
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 0, 0, 1, 1);
        repeat (12) cycle(0, 0, 0, 0, 1);
        e0 = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01};
        e1 = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        check("blk1_len", 0, 32'(cap0.size()), 32'd6);
        check("blk1_len", 1, 32'(cap1.size()), 32'd6);
        for (int i = 0; i < 6 && i < cap0.size(); i++) check("blk1_bits", 0, 32'(cap0[i]), 32'(e0[i]));
        for (int i = 0; i < 6 && i < cap1.size(); i++) check("blk1_bits", 1, 32'(cap1[i]), 32'(e1[i]));
        check("blk1_sent_end", 0, 32'(sent0), 32'd0);

        // Odd-length block followed by a one-pair block: phase must restart at 0.
        cap0.delete();
        cap1.delete();
        cycle(1, 1, 1, 0, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(1, 1, 1, 1, 1);
        cycle(1, 0, 1, 1, 1);
        repeat (12) cycle(0, 0, 0, 0, 1);
        check("blk2_len", 0, 32'(cap0.size()), 32'd7);
        check("blk2_len", 1, 32'(cap1.size()), 32'd6);
        if (cap0.size() == 7) begin
            check("blk2_first_b0", 0, 32'(cap0[5]), 32'(2'b00));
            check("blk2_first_b1", 0, 32'(cap0[6]), 32'(2'b11));
        end

        // Stalled consumer: fill past capacity, then leave SEND0 for SEND1 and reset.
        for (int i = 0; i < 12; i++) cycle(1, i[0], 1'b1, 0, 0);
        @(negedge clk);
        check("stall_in_ready", 0, 32'(bus0.in_ready), 32'd0);
        check("stall_overflow", 0, 32'(ovf0), 32'd1);
        check("stall_overflow", 1, 32'(ovf1), 32'd1);
        check("stall_out_bit", 0, 32'(bus0.out_bit), 32'd0);
        compare(0);
        compare(1);
        drive(0, 0, 0, 0, 1);
        model_step(0);
        model_step(1);
        cycle(0, 0, 0, 0, 0);
        do_reset();

        // Randomised traffic in segments of differing producer/consumer pressure.
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin vp = 50;  rp = 90;  end
                1: begin vp = 90;  rp = 40;  end
                2: begin vp = 30;  rp = 100; end
                default: begin vp = 100; rp = 100; end
            endcase
            for (int i = 0; i < 1000; i++) begin
                cycle(1'($urandom_range(0, 99) < vp), 1'($urandom), 1'($urandom),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) < rp));
            end
        end
        repeat (20) cycle(0, 0, 0, 0, 1);
        do_reset();
        repeat (4) cycle(0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
